// File: rtl/ssd_scan_driver.sv
// -----------------------------------------------------------------------------
// ssd_scan_driver
// Time-multiplexes a 16-bit value onto a 4-digit common-anode seven-segment
// display. Each digit stays lit for REFRESH_DIV clock cycles. One nibble per
// cycle goes to the downstream hex-to-segment decoder, together with the
// matching active-low anode enable.
//
// A loaded value is held in a pending register. It reaches the displayed
// (shadow) value only at a frame boundary, so a frame never shows a mix of
// old and new digits. Leading-zero blanking is optional.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   value_in     in  16   value to display; nibble k drives digit k (0 = rightmost)
//   load         in   1   one-cycle strobe: capture value_in
//   blank_lz     in   1   1 = blank leading zero digits (digit 0 never blanked)
//   nibble       out  4   hex digit for the seven-segment decoder
//   an           out  4   anode enables, active-low (4'b1111 = blank)
//   digit_idx    out  2   index of the digit currently being scanned
//   upd_pending  out  1   a loaded value is waiting for the next frame boundary
// -----------------------------------------------------------------------------
module ssd_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx,
    output logic        upd_pending
);

    logic [CNT_W-1:0] r_div_cnt;
    logic [1:0]       r_digit_idx;
    logic [15:0]      r_shadow;
    logic [15:0]      r_pending;
    logic             r_upd_pending;
    logic [3:0]       r_an;
    logic [3:0]       r_nibble;

    logic             w_step;
    logic             w_boundary;
    logic [3:0]       w_lz;
    logic             w_blanked;
    logic [3:0]       w_nibble_sel;
    logic [3:0]       w_an_sel;

    // Divider terminal count and frame boundary (the step that wraps digit 3 -> 0)
    always_comb begin
        w_step     = (r_div_cnt == CNT_W'(REFRESH_DIV - 1));
        w_boundary = w_step && (r_digit_idx == 2'd3);
    end

    // Per-digit select of the shadow nibble, the anode pattern and the blank flag
    always_comb begin
        w_lz         = 4'b0000;
        w_nibble_sel = 4'h0;
        w_an_sel     = 4'b1111;
        // w_lz[k]: nibble k and every higher nibble are zero; digit 0 is never blanked
        w_lz[3]      = (r_shadow[15:12] == 4'h0);
        w_lz[2]      = w_lz[3] && (r_shadow[11:8] == 4'h0);
        w_lz[1]      = w_lz[2] && (r_shadow[7:4] == 4'h0);
        w_lz[0]      = 1'b0;
        case (r_digit_idx)
            2'd0: begin
                w_nibble_sel = r_shadow[3:0];
                w_an_sel     = 4'b1110;
            end
            2'd1: begin
                w_nibble_sel = r_shadow[7:4];
                w_an_sel     = 4'b1101;
            end
            2'd2: begin
                w_nibble_sel = r_shadow[11:8];
                w_an_sel     = 4'b1011;
            end
            2'd3: begin
                w_nibble_sel = r_shadow[15:12];
                w_an_sel     = 4'b0111;
            end
            default: begin
                w_nibble_sel = 4'h0;
                w_an_sel     = 4'b1111;
            end
        endcase
        w_blanked = blank_lz && w_lz[r_digit_idx];
    end

    // Refresh divider and digit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt   <= {CNT_W{1'b0}};
            r_digit_idx <= 2'd0;
        end else if (w_step) begin
            r_div_cnt   <= {CNT_W{1'b0}};
            r_digit_idx <= r_digit_idx + 2'd1;
        end else begin
            r_div_cnt   <= r_div_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            r_digit_idx <= r_digit_idx;
        end
    end

    // Double-buffered value: pending captures loads, shadow updates only at a boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending     <= 16'h0000;
            r_shadow      <= 16'h0000;
            r_upd_pending <= 1'b0;
        end else if (w_boundary && load) begin
            // A load that lands on the boundary bypasses the pending register
            r_shadow      <= value_in;
            r_upd_pending <= 1'b0;
        end else if (w_boundary) begin
            if (r_upd_pending) begin
                r_shadow <= r_pending;
            end else begin
                r_shadow <= r_shadow;
            end
            r_upd_pending <= 1'b0;
        end else if (load) begin
            r_pending     <= value_in;
            r_upd_pending <= 1'b1;
        end else begin
            r_upd_pending <= r_upd_pending;
        end
    end

    // Registered display outputs, one cycle behind digit_idx/shadow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an     <= 4'b1111;
            r_nibble <= 4'h0;
        end else begin
            r_an     <= w_blanked ? 4'b1111 : w_an_sel;
            r_nibble <= w_nibble_sel;
        end
    end

    assign nibble      = r_nibble;
    assign an          = r_an;
    assign digit_idx   = r_digit_idx;
    assign upd_pending = r_upd_pending;

endmodule
